match_ctrl: RTL and testbench

Match-sequencing controller for the ball-and-paddle game.
- Owns the two 6-bit player scores and sequences attract (demo), serve, play, point and game-over phases.
- Gates ball motion and drives the demo score counter's enable.
- Muxes demo or live scores onto the score display outputs.
- Sits between the ball/collision logic (point pulses), the start button and the score display.

---
 rtl/match_pkg.sv | 25 ++
 rtl/pause_timer.sv | 28 ++
 rtl/match_ctrl.sv | 173 +++++++++++++++++
 tb/tb_match_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared encodings for the match-sequencing controller: phase codes, score width,
// winner codes and the saturating score increment.
package match_pkg;

    localparam int SCORE_W = 6;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 6'd63;

    typedef enum logic [2:0] {
        ATTRACT = 3'd0,
        SERVE   = 3'd1,
        PLAY    = 3'd2,
        POINT   = 3'd3,
        OVER    = 3'd4,
        DEUCE   = 3'd5
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + 6'd1;
    endfunction

endpackage

// File: rtl/pause_timer.sv
// Loadable down-counter shared by the serve pause and the game-over hold.
// Load wins over count; the count rests at zero rather than wrapping.
module pause_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/match_ctrl.sv
// Match sequencer: scores, serve/play/point/game-over phases, ball gating and score mux.
// Optional MATCH_CTRL_WIN_BY_TWO_EN: win needs a two-point margin (63 always wins) and adds DEUCE phase.
//
// state   | meaning
// ATTRACT | demo running, demo score displayed, waiting for start
// SERVE   | ball held for the serve pause
// PLAY    | ball moving, waiting for a point pulse
// POINT   | one cycle to evaluate the win condition
// OVER    | final score and winner held, then back to ATTRACT
module match_ctrl
    import match_pkg::*;
#(
    parameter int WIN_SCORE    = 10,
    parameter int PAUSE_CYCLES = 25000000,
    parameter int OVER_CYCLES  = 50000000,
    parameter int CNT_W        = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pt1,
    input  logic               pt2,
    input  logic [SCORE_W-1:0] demo_score_in,
    output logic               demo_en,
    output logic               ball_en,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner,
    output logic [2:0]         phase
);

    localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   PAUSE_V = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   OVER_V  = CNT_W'(OVER_CYCLES - 1);

    state_t             state_q, state_nxt;
    state_t             phase_q, phase_nxt;
    logic [SCORE_W-1:0] s1_q, s1_nxt;
    logic [SCORE_W-1:0] s2_q, s2_nxt;
    logic               dir_q, dir_nxt;
    logic [1:0]         win_q, win_nxt;
    logic               ball_en_q, demo_en_q;
    logic               tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0]   tmr_val;
    logic               win1, win2;

`ifdef MATCH_CTRL_WIN_BY_TWO_EN
    localparam logic [SCORE_W-1:0] DEUCE_S = WIN_S - 6'd1;
    assign win1 = (s1_q == SCORE_MAX) ||
                  ((s1_q >= WIN_S) && ({1'b0, s1_q} >= ({1'b0, s2_q} + 7'd2)));
    assign win2 = (s2_q == SCORE_MAX) ||
                  ((s2_q >= WIN_S) && ({1'b0, s2_q} >= ({1'b0, s1_q} + 7'd2)));
`else
    assign win1 = (s1_q >= WIN_S);
    assign win2 = (s2_q >= WIN_S);
`endif

    assign tmr_en = (state_q == SERVE) || (state_q == OVER);

    pause_timer #(
        .CNT_W (CNT_W)
    ) u_pause_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ATTRACT;
            phase_q   <= ATTRACT;
            s1_q      <= '0;
            s2_q      <= '0;
            dir_q     <= 1'b0;
            win_q     <= WIN_NONE;
            ball_en_q <= 1'b0;
            demo_en_q <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            phase_q   <= phase_nxt;
            s1_q      <= s1_nxt;
            s2_q      <= s2_nxt;
            dir_q     <= dir_nxt;
            win_q     <= win_nxt;
            ball_en_q <= (state_nxt == PLAY);
            demo_en_q <= (state_nxt == ATTRACT);
        end
    end

    always_comb begin
        state_nxt = state_q;
        s1_nxt    = s1_q;
        s2_nxt    = s2_q;
        dir_nxt   = dir_q;
        win_nxt   = win_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        case (state_q)
            ATTRACT: ;
            SERVE: begin
                if (tmr_zero) state_nxt = PLAY;
            end
            PLAY: begin
                if (pt1 || pt2) begin
                    state_nxt = POINT;
                    // Serve goes toward the player who lost the rally; a let changes nothing.
                    if (pt1 && !pt2) begin
                        s1_nxt  = sat_inc(s1_q);
                        dir_nxt = 1'b1;
                    end else if (pt2 && !pt1) begin
                        s2_nxt  = sat_inc(s2_q);
                        dir_nxt = 1'b0;
                    end
                end
            end
            POINT: begin
                tmr_load = 1'b1;
                if (win1) begin
                    win_nxt   = WIN_P1;
                    tmr_val   = OVER_V;
                    state_nxt = OVER;
                end else if (win2) begin
                    win_nxt   = WIN_P2;
                    tmr_val   = OVER_V;
                    state_nxt = OVER;
                end else begin
                    tmr_val   = PAUSE_V;
                    state_nxt = SERVE;
                end
            end
            OVER: begin
                if (tmr_zero) begin
                    state_nxt = ATTRACT;
                    win_nxt   = WIN_NONE;
                end
            end
            default: state_nxt = ATTRACT;
        endcase

        if (start && ((state_q == ATTRACT) || (state_q == OVER))) begin
            state_nxt = SERVE;
            s1_nxt    = '0;
            s2_nxt    = '0;
            win_nxt   = WIN_NONE;
            dir_nxt   = 1'b0;
            tmr_load  = 1'b1;
            tmr_val   = PAUSE_V;
        end
    end

    always_comb begin
        phase_nxt = state_nxt;
`ifdef MATCH_CTRL_WIN_BY_TWO_EN
        if ((state_nxt != ATTRACT) && (s1_nxt == s2_nxt) && (s1_nxt >= DEUCE_S)) begin
            phase_nxt = DEUCE;
        end
`endif
    end

    assign score1    = (state_q == ATTRACT) ? demo_score_in : s1_q;
    assign score2    = (state_q == ATTRACT) ? demo_score_in : s2_q;
    assign demo_en   = demo_en_q;
    assign ball_en   = ball_en_q;
    assign serve_dir = dir_q;
    assign winner    = win_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl with short pauses (serve 4, game-over 8, win at 3).
module tb_match_ctrl;

    localparam int WIN = 3;

    logic       clk = 1'b0;
    logic       rst, start, pt1, pt2;
    logic [5:0] demo_score_in;
    logic       demo_en, ball_en, serve_dir;
    logic [5:0] score1, score2;
    logic [1:0] winner;
    logic [2:0] phase;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [5:0] s1;
        logic [5:0] s2;
        logic       dir;
        logic [1:0] win;
        logic [2:0] ph;
    } exp_t;

    exp_t sb[$];

    int   m_s1, m_s2, m_dir, m_win;
    bit   m_over;

    match_ctrl #(
        .WIN_SCORE    (WIN),
        .PAUSE_CYCLES (4),
        .OVER_CYCLES  (8),
        .CNT_W        (26)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pt1           (pt1),
        .pt2           (pt2),
        .demo_score_in (demo_score_in),
        .demo_en       (demo_en),
        .ball_en       (ball_en),
        .serve_dir     (serve_dir),
        .score1        (score1),
        .score2        (score2),
        .winner        (winner),
        .phase         (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit wins(input int a, input int b);
`ifdef MATCH_CTRL_WIN_BY_TWO_EN
        return (a == 63) || ((a >= WIN) && (a >= b + 2));
`else
        return (a >= WIN);
`endif
    endfunction

    function automatic bit deuce(input int a, input int b);
`ifdef MATCH_CTRL_WIN_BY_TWO_EN
        return (a == b) && (a >= WIN - 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int sat(input int v);
        return (v >= 63) ? 63 : v + 1;
    endfunction

    task automatic start_match(input string tag);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0; m_over = 0;
        chk({tag, "_phase"}, phase, 1);
        chk({tag, "_score1"}, score1, 0);
        chk({tag, "_score2"}, score2, 0);
        chk({tag, "_winner"}, winner, 0);
        chk({tag, "_demo_en"}, demo_en, 0);
        chk({tag, "_dir"}, serve_dir, 0);
    endtask

    // Entered at the negedge just after the SERVE entry edge.
    task automatic serve_wait(input string tag, input bit inject);
        if (inject) begin
            pt1 = 1'b1;
            cyc(1);
            pt1 = 1'b0;
            cyc(2);
        end else begin
            cyc(3);
        end
        chk({tag, "_ball_held"}, ball_en, 0);
        cyc(1);
        chk({tag, "_ball_go"}, ball_en, 1);
        chk({tag, "_play_phase"}, phase, deuce(m_s1, m_s2) ? 5 : 2);
        chk({tag, "_s1_play"}, score1, m_s1);
        chk({tag, "_s2_play"}, score2, m_s2);
    endtask

    task automatic do_point(input string tag, input bit a, input bit b);
        exp_t e;
        if (a && !b) begin
            m_s1 = sat(m_s1); m_dir = 1;
        end else if (b && !a) begin
            m_s2 = sat(m_s2); m_dir = 0;
        end
        m_over = 1'b1;
        if (wins(m_s1, m_s2))      m_win = 1;
        else if (wins(m_s2, m_s1)) m_win = 2;
        else                       m_over = 1'b0;
        e.s1 = 6'(m_s1); e.s2 = 6'(m_s2); e.dir = m_dir[0]; e.win = 2'(m_win);
        e.ph = m_over ? 3'd4 : (deuce(m_s1, m_s2) ? 3'd5 : 3'd1);
        sb.push_back(e);

        pt1 = a; pt2 = b;
        cyc(1);
        pt1 = 1'b0; pt2 = 1'b0;
        chk({tag, "_point_phase"}, phase, deuce(m_s1, m_s2) ? 5 : 3);
        chk({tag, "_point_ball"}, ball_en, 0);
        cyc(1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_score1"}, score1, e.s1);
            chk({tag, "_score2"}, score2, e.s2);
            chk({tag, "_dir"}, serve_dir, e.dir);
            chk({tag, "_winner"}, winner, e.win);
            chk({tag, "_phase"}, phase, e.ph);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pt1 = 1'b0; pt2 = 1'b0;
        demo_score_in = 6'd7;
        cyc(3);
        chk("rst_phase", phase, 0);
        chk("rst_demo_en", demo_en, 1);
        chk("rst_ball_en", ball_en, 0);
        rst = 1'b0;
        cyc(20);
        chk("idle_demo_en", demo_en, 1);
        chk("idle_ball_en", ball_en, 0);
        chk("idle_score1", score1, 7);
        chk("idle_score2", score2, 7);
        chk("idle_winner", winner, 0);
        chk("idle_dir", serve_dir, 0);

        // Match 1: points, a let, ignored inputs, player 1 wins, timeout back to attract.
        start_match("m1_start");
        serve_wait("m1_serve0", 1'b0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("start_in_play_ignored", phase, 2);
        do_point("m1_p1", 1'b1, 1'b0);
        serve_wait("m1_serve1", 1'b0);
        do_point("m1_p2", 1'b0, 1'b1);
        serve_wait("m1_serve2", 1'b1);
        do_point("m1_let", 1'b1, 1'b1);
        serve_wait("m1_serve3", 1'b0);
        for (int i = 0; i < 6 && !m_over; i++) begin
            do_point("m1_run", 1'b1, 1'b0);
            if (!m_over) serve_wait("m1_run_serve", 1'b0);
        end
        chk("m1_over", m_over, 1);
        chk("m1_winner_code", winner, 1);
        cyc(7);
        chk("m1_hold_phase", phase, 4);
        chk("m1_hold_score1", score1, m_s1);
        chk("m1_hold_winner", winner, 1);
        cyc(1);
        chk("m1_attract_phase", phase, 0);
        chk("m1_attract_winner", winner, 0);
        chk("m1_attract_demo_en", demo_en, 1);
        chk("m1_attract_score1", score1, 7);

        // Match 2: quick win, then restart from OVER.
        start_match("m2_start");
        serve_wait("m2_serve0", 1'b0);
        for (int i = 0; i < 6 && !m_over; i++) begin
            do_point("m2_run", 1'b1, 1'b0);
            if (!m_over) serve_wait("m2_run_serve", 1'b0);
        end
        chk("m2_winner", winner, 1);
        cyc(2);
        start_match("m2_restart");
        serve_wait("m2_serve_new", 1'b0);

        // Reset mid-play with s1 = 2.
        do_point("m3_p1a", 1'b1, 1'b0);
        serve_wait("m3_sa", 1'b0);
        do_point("m3_p1b", 1'b1, 1'b0);
        serve_wait("m3_sb", 1'b0);
        chk("m3_s1_two", score1, 2);
        #2 rst = 1'b1;
        #1;
        chk("m3_rst_phase", phase, 0);
        chk("m3_rst_ball", ball_en, 0);
        chk("m3_rst_demo_en", demo_en, 1);
        chk("m3_rst_winner", winner, 0);
        cyc(2);
        rst = 1'b0;
        demo_score_in = 6'd9;
        cyc(2);
        chk("m3_attract_score2", score2, 9);

        // Match 4: 2-2 then player 1 until the win condition holds.
        start_match("m4_start");
        serve_wait("m4_s0", 1'b0);
        do_point("m4_a", 1'b1, 1'b0);
        serve_wait("m4_sa", 1'b0);
        do_point("m4_b", 1'b0, 1'b1);
        serve_wait("m4_sb", 1'b0);
        do_point("m4_c", 1'b1, 1'b0);
        serve_wait("m4_sc", 1'b0);
        do_point("m4_d", 1'b0, 1'b1);
        serve_wait("m4_sd", 1'b0);
        for (int i = 0; i < 6 && !m_over; i++) begin
            do_point("m4_run", 1'b1, 1'b0);
            if (!m_over) serve_wait("m4_run_serve", 1'b0);
        end
        chk("m4_over", m_over, 1);
        chk("m4_final_s1", score1, m_s1);
        chk("m4_winner", winner, 1);
        chk("m4_sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
